// File: rtl/output_buffer_serializer_if.sv
// Handshake bundle between the PE-array output stage, the serializer and the activation memory.
// The slave modport is the serializer's view; master is the producer/consumer side.
interface output_buffer_serializer_if #(
  parameter int unsigned N_DIM_ARRAY    = 4,
  parameter int unsigned ACT_DATA_WIDTH = 8,
  parameter int unsigned OUT_LANES      = 2,
  parameter int unsigned DEPTH          = 8
);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic [2:0]                              mode;
  logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0]   in_word;
  logic [31:0]                             in_addr;
  logic                                    in_valid;
  logic                                    in_ready;
  logic [OUT_LANES*ACT_DATA_WIDTH-1:0]     out_word;
  logic [31:0]                             out_addr;
  logic                                    out_valid;
  logic                                    out_ready;
  logic                                    out_last;
  logic [OCC_W-1:0]                        occupancy;

  modport master (
    output mode, in_word, in_addr, in_valid, out_ready,
    input  in_ready, out_word, out_addr, out_valid, out_last, occupancy
  );

  modport slave (
    input  mode, in_word, in_addr, in_valid, out_ready,
    output in_ready, out_word, out_addr, out_valid, out_last, occupancy
  );
endinterface

// File: rtl/output_buffer_serializer.sv
// Row-word FIFO that serialises each buffered entry into OUT_LANES-wide beats.
// CNN entries emit N_DIM_ARRAY/OUT_LANES beats, any other mode emits a single beat.
module output_buffer_serializer #(
  parameter int unsigned N_DIM_ARRAY    = 4,
  parameter int unsigned ACT_DATA_WIDTH = 8,
  parameter int unsigned OUT_LANES      = 2,
  parameter int unsigned DEPTH          = 8,
  parameter logic [2:0]  MODE_CNN       = 3'd1
) (
  input  logic                      clk,
  input  logic                      reset,
  output_buffer_serializer_if.slave bus
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned IN_W  = N_DIM_ARRAY * ACT_DATA_WIDTH;
  localparam int unsigned OUT_W = OUT_LANES * ACT_DATA_WIDTH;
  localparam int unsigned BPE   = N_DIM_ARRAY / OUT_LANES;
  localparam int unsigned BW    = (BPE > 1) ? $clog2(BPE) : 1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BPE - 1);
  localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P     = PW'(1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IN_W-1:0] r_mem_word [DEPTH];
  logic [31:0]     r_mem_addr [DEPTH];
  logic            r_mem_cnn  [DEPTH];

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_occ;
  logic [BW-1:0]   r_beat_idx;

  logic            w_empty;
  logic            w_wr;
  logic            w_beat_acc;
  logic            w_last;
  logic            w_pop;
  logic            w_more;
  logic            w_head_cnn;
  logic [IN_W-1:0] w_head_word;
  logic [31:0]     w_head_addr;
  logic [OUT_W-1:0] w_beats [BPE];

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign bus.in_ready = (r_occ != DEPTH_P);
  assign w_wr        = bus.in_valid && bus.in_ready;

  assign w_head_word = r_mem_word[r_rd_ptr[AW-1:0]];
  assign w_head_addr = r_mem_addr[r_rd_ptr[AW-1:0]];
  assign w_head_cnn  = r_mem_cnn[r_rd_ptr[AW-1:0]];

  // FC entries never advance beat_idx, so they always present lanes 0..OUT_LANES-1.
  assign w_last      = !w_head_cnn || (r_beat_idx == LAST_BEAT);
  assign w_beat_acc  = (r_state == SEND) && bus.out_ready;
  assign w_pop       = w_beat_acc && w_last;
  assign w_more      = (r_occ != ONE_P) || w_wr;

  assign bus.occupancy = r_occ;

  always_comb begin
    for (int unsigned b = 0; b < BPE; b++) begin
      w_beats[b] = w_head_word[b*OUT_W +: OUT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_word[r_wr_ptr[AW-1:0]] <= bus.in_word;
      r_mem_addr[r_wr_ptr[AW-1:0]] <= bus.in_addr;
      r_mem_cnn[r_wr_ptr[AW-1:0]]  <= (bus.mode == MODE_CNN);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_beat_idx <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_beat_acc) begin
        r_beat_idx <= w_last ? '0 : r_beat_idx + 1'b1;
      end
      r_occ <= r_occ + PW'(w_wr) - PW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.out_valid = 1'b0;
    bus.out_word  = '0;
    bus.out_addr  = '0;
    bus.out_last  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        bus.out_valid = 1'b1;
        bus.out_word  = w_beats[r_beat_idx];
        bus.out_addr  = w_head_addr + 32'(r_beat_idx);
        bus.out_last  = w_last;
        // Staying in SEND after the final pop lets back-to-back entries stream at one beat per cycle.
        if (w_pop) begin
          w_state_nxt = w_more ? SEND : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_output_buffer_serializer.sv
// Bench for output_buffer_serializer: constant vector table, directed corner sequences and
// randomized traffic, all checked against a beat-stream queue model.
module tb_output_buffer_serializer;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned OL = 2;
  localparam int unsigned D  = 8;
  localparam int unsigned IW = N * W;
  localparam int unsigned OW = OL * W;

  logic clk;
  logic rst_n;

  output_buffer_serializer_if #(
    .N_DIM_ARRAY(N), .ACT_DATA_WIDTH(W), .OUT_LANES(OL), .DEPTH(D)
  ) bus ();

  output_buffer_serializer #(
    .N_DIM_ARRAY(N), .ACT_DATA_WIDTH(W), .OUT_LANES(OL), .DEPTH(D), .MODE_CNN(3'd1)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] word;
    logic [31:0]   addr;
    logic          last;
  } beat_t;

  typedef struct {
    logic        iv;
    logic [2:0]  md;
    logic [31:0] wd;
    logic [31:0] ad;
    logic        ordy;
    logic        ev;
    logic [15:0] ew;
    logic [31:0] ea;
    logic        el;
    logic        erdy;
    logic [3:0]  eocc;
  } vec_t;

  beat_t m_q[$];
  int    m_occ;
  bit    m_valid;

  int checks;
  int failures;
  int obs_beats;
  int obs_run;
  int obs_cnt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic apply(input logic rn, input logic iv, input logic [2:0] md,
                       input logic [IW-1:0] wd, input logic [31:0] ad,
                       input logic ordy, input bit mchk);
    beat_t         hb;
    beat_t         nb;
    bit            exp_rdy;
    bit            wr;
    int            occ0;
    int            n;
    logic [IW-1:0] wv;
    @(negedge clk);
    rst_n         = rn;
    bus.in_valid  = iv;
    bus.mode      = md;
    bus.in_word   = wd;
    bus.in_addr   = ad;
    bus.out_ready = ordy;
    #1;
    exp_rdy = (m_occ != D);
    if (m_valid && m_q.size() > 0) hb = m_q[0];
    else hb = '{word: '0, addr: '0, last: 1'b0};
    if (mchk) begin
      chk("in_ready",  bus.in_ready,  exp_rdy);
      chk("out_valid", bus.out_valid, m_valid);
      chk("occupancy", bus.occupancy, m_occ);
      chk("out_word",  bus.out_word,  hb.word);
      chk("out_addr",  bus.out_addr,  hb.addr);
      chk("out_last",  bus.out_last,  hb.last);
    end
    if (rn && ordy && bus.out_valid === 1'b1) begin
      obs_beats++;
      obs_run++;
      if (bus.out_last === 1'b1) begin
        obs_cnt.push_back(obs_run);
        obs_run = 0;
      end
    end
    if (!rn) begin
      m_q.delete();
      m_occ   = 0;
      m_valid = 1'b0;
    end else begin
      wr   = iv && exp_rdy;
      occ0 = m_occ;
      if (m_valid && ordy && m_q.size() > 0) begin
        if (hb.last) m_occ--;
        void'(m_q.pop_front());
      end
      if (wr) begin
        wv = wd;
        n  = (md == 3'd1) ? int'(N / OL) : 1;
        for (int b = 0; b < n; b++) begin
          nb.word = wv[b*OW +: OW];
          nb.addr = ad + 32'(b);
          nb.last = (b == n - 1);
          m_q.push_back(nb);
        end
        m_occ++;
      end
      m_valid = m_valid ? (m_occ > 0) : (occ0 > 0);
    end
  endtask

  task automatic idle(input logic ordy);
    apply(1'b1, 1'b0, 3'd0, '0, '0, ordy, 1'b1);
  endtask

  task automatic fill_and_drain(input int base);
    for (int i = 0; i < 9; i++) begin
      apply(1'b1, 1'b1, 3'd1, IW'($urandom), 32'(base + i * 16), 1'b0, 1'b1);
    end
    idle(1'b0);
    chk("full_in_ready", bus.in_ready, 1'b0);
    chk("full_occ", bus.occupancy, 8);
    obs_beats = 0;
    for (int i = 0; i < 20; i++) idle(1'b1);
    chk("drain_beats", obs_beats, 16);
    chk("drain_occ", bus.occupancy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    logic [7:0] bp_rdy;
    checks    = 0;
    failures  = 0;
    obs_beats = 0;
    obs_run   = 0;
    m_occ     = 0;
    m_valid   = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mode      = 3'd0;
    bus.in_word   = '0;
    bus.in_addr   = '0;
    bus.out_ready = 1'b0;

    tbl[0] = '{1'b1, 3'd1, 32'h44332211, 32'h100, 1'b1, 1'b0, 16'h0000, 32'h000, 1'b0, 1'b1, 4'd0};
    tbl[1] = '{1'b0, 3'd1, 32'h00000000, 32'h000, 1'b1, 1'b0, 16'h0000, 32'h000, 1'b0, 1'b1, 4'd1};
    tbl[2] = '{1'b0, 3'd1, 32'h00000000, 32'h000, 1'b1, 1'b1, 16'h2211, 32'h100, 1'b0, 1'b1, 4'd1};
    tbl[3] = '{1'b0, 3'd1, 32'h00000000, 32'h000, 1'b1, 1'b1, 16'h4433, 32'h101, 1'b1, 1'b1, 4'd1};
    tbl[4] = '{1'b1, 3'd0, 32'hDDCCBBAA, 32'h020, 1'b1, 1'b0, 16'h0000, 32'h000, 1'b0, 1'b1, 4'd0};
    tbl[5] = '{1'b0, 3'd0, 32'h00000000, 32'h000, 1'b1, 1'b0, 16'h0000, 32'h000, 1'b0, 1'b1, 4'd1};
    tbl[6] = '{1'b0, 3'd0, 32'h00000000, 32'h000, 1'b1, 1'b1, 16'hBBAA, 32'h020, 1'b1, 1'b1, 4'd1};
    tbl[7] = '{1'b0, 3'd0, 32'h00000000, 32'h000, 1'b1, 1'b0, 16'h0000, 32'h000, 1'b0, 1'b1, 4'd0};

    apply(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      apply(1'b1, tbl[i].iv, tbl[i].md, tbl[i].wd, tbl[i].ad, tbl[i].ordy, 1'b1);
      chk($sformatf("vec%0d_valid", i), bus.out_valid, tbl[i].ev);
      chk($sformatf("vec%0d_word", i),  bus.out_word,  tbl[i].ew);
      chk($sformatf("vec%0d_addr", i),  bus.out_addr,  tbl[i].ea);
      chk($sformatf("vec%0d_last", i),  bus.out_last,  tbl[i].el);
      chk($sformatf("vec%0d_rdy", i),   bus.in_ready,  tbl[i].erdy);
      chk($sformatf("vec%0d_occ", i),   bus.occupancy, tbl[i].eocc);
    end

    // Fill to full twice so both pointers wrap.
    fill_and_drain(32'h200);
    fill_and_drain(32'h800);

    // Backpressure hold on a CNN entry.
    apply(1'b1, 1'b1, 3'd1, 32'h87654321, 32'h500, 1'b0, 1'b1);
    idle(1'b0);
    obs_beats = 0;
    bp_rdy = 8'b0001_0010;
    for (int i = 0; i < 5; i++) begin
      idle(bp_rdy[i]);
      if (i == 3) begin
        chk("bp_hold_word", bus.out_word, 16'h8765);
        chk("bp_hold_addr", bus.out_addr, 32'h501);
      end
    end
    idle(1'b1);
    chk("bp_beats", obs_beats, 2);

    // Mixed modes back-to-back, mode input scrambled while draining.
    obs_cnt.delete();
    obs_run = 0;
    apply(1'b1, 1'b1, 3'd1, 32'h0A0B0C0D, 32'h300, 1'b1, 1'b1);
    apply(1'b1, 1'b1, 3'd0, 32'h1A1B1C1D, 32'h310, 1'b1, 1'b1);
    apply(1'b1, 1'b1, 3'd1, 32'h2A2B2C2D, 32'h320, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) apply(1'b1, 1'b0, 3'($urandom_range(0, 7)), '0, '0, 1'b1, 1'b1);
    chk("mix_entries", obs_cnt.size(), 3);
    if (obs_cnt.size() == 3) begin
      chk("mix_cnt0", obs_cnt[0], 2);
      chk("mix_cnt1", obs_cnt[1], 1);
      chk("mix_cnt2", obs_cnt[2], 2);
    end

    // Reset after the first beat of a CNN entry with three queued.
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b1, 3'd1, IW'($urandom), 32'(32'h600 + i * 16), 1'b0, 1'b1);
    end
    idle(1'b0);
    idle(1'b1);
    apply(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
    idle(1'b0);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_occ",   bus.occupancy, 0);
    chk("rst_rdy",   bus.in_ready,  1'b1);
    apply(1'b1, 1'b1, 3'd1, 32'h88776655, 32'h400, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("rst_new_word", bus.out_word, 16'h6655);
    chk("rst_new_addr", bus.out_addr, 32'h400);
    chk("rst_new_last", bus.out_last, 1'b0);
    idle(1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      apply(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 99) < 60),
            ($urandom_range(0, 1) != 0) ? 3'd1 : 3'($urandom_range(0, 7)),
            IW'($urandom), $urandom,
            ($urandom_range(0, 99) < 65), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
